// File: rtl/sl_fifo_transmitter.sv
// Register-mapped transmit FIFO driving a two-wire SL (SL0/SL1) serial line.
// Each word is sent LSB first with odd parity, a STOP (both low) and an idle GAP.
module sl_fifo_transmitter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        SL0,
  output logic        SL1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, BIT_ACT, BIT_REST, PAR_ACT, PAR_REST, STOP, GAP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [5:0]        cfg_len;
  logic [2:0]        cfg_fm;
  logic [DATA_W-1:0] shift;
  logic [5:0]        bits_left;
  logic [7:0]        half;
  logic [8:0]        timer;
  logic              parity;

  logic       data_wr, cfg_wr, flush, fifo_full, fifo_empty, push, pop, busy;
  logic [5:0] eff_len;
  logic [7:0] eff_half;
  logic       unused_din;

  assign data_wr    = wr_en && (addr == 2'd0);
  assign cfg_wr     = wr_en && (addr == 2'd1);
  assign flush      = cfg_wr && d_in[8];
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = data_wr && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty && !flush;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign unused_din = ^d_in;

  always_comb begin
    eff_len = {cfg_len[5:1], 1'b0};
    if (eff_len < 6'd8)
      eff_len = 6'd8;
    else if (eff_len > 6'(DATA_W))
      eff_len = 6'(DATA_W);
    eff_half = (cfg_fm > 3'd5) ? 8'd128 : (8'd4 << cfg_fm);
  end

  always_comb begin
    d_out = '0;
    case (addr)
      2'd1: d_out[9:0] = {cfg_fm, 1'b0, cfg_len};
      2'd2: begin
        d_out[CNT_W-1:0] = count;
        d_out[16]        = busy;
        d_out[17]        = fifo_full;
        d_out[18]        = fifo_empty;
        d_out[24]        = overflow;
      end
      default: d_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= d_in[DATA_W-1:0];
  end

  // Occupancy uses the pre-edge count, so a pop in the same cycle cannot make room for a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
      if (data_wr && fifo_full)
        overflow <= 1'b1;
      else if (wr_en && (addr == 2'd2) && d_in[24])
        overflow <= 1'b0;
    end
  end

  // Bit 8 of CONFIG is the flush strobe, so the middle freq_mode bit always stores 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_len <= 6'd8;
      cfg_fm  <= 3'd0;
    end else if (cfg_wr) begin
      cfg_len <= d_in[5:0];
      cfg_fm  <= {d_in[9], 1'b0, d_in[7]};
    end
  end

  // Line levels are registered from the current state, one cycle behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bits_left <= '0;
      half      <= 8'd4;
      timer     <= '0;
      parity    <= 1'b1;
      SL0       <= 1'b1;
      SL1       <= 1'b1;
    end else if (flush) begin
      state <= IDLE;
      timer <= '0;
      SL0   <= 1'b1;
      SL1   <= 1'b1;
    end else begin
      case (state)
        BIT_ACT: begin SL0 <= shift[0]; SL1 <= ~shift[0]; end
        PAR_ACT: begin SL0 <= parity;   SL1 <= ~parity;   end
        STOP:    begin SL0 <= 1'b0;     SL1 <= 1'b0;      end
        default: begin SL0 <= 1'b1;     SL1 <= 1'b1;      end
      endcase

      if (state == IDLE) begin
        if (pop) begin
          shift     <= mem[rd_ptr];
          bits_left <= eff_len;
          half      <= eff_half;
          timer     <= {1'b0, eff_half} - 9'd1;
          parity    <= 1'b1;
          state     <= BIT_ACT;
        end
      end else if (timer != '0) begin
        timer <= timer - 9'd1;
      end else begin
        case (state)
          BIT_ACT: begin
            parity <= parity ^ shift[0];
            timer  <= {1'b0, half} - 9'd1;
            state  <= BIT_REST;
          end
          BIT_REST: begin
            timer <= {1'b0, half} - 9'd1;
            if (bits_left == 6'd1) begin
              state <= PAR_ACT;
            end else begin
              shift     <= shift >> 1;
              bits_left <= bits_left - 6'd1;
              state     <= BIT_ACT;
            end
          end
          PAR_ACT: begin
            timer <= {1'b0, half} - 9'd1;
            state <= PAR_REST;
          end
          PAR_REST: begin
            timer <= {half, 1'b0} - 9'd1;
            state <= STOP;
          end
          STOP: begin
            timer <= {half, 1'b0} - 9'd1;
            state <= GAP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sl_fifo_transmitter.sv
// Self-checking bench: a queue-based line-waveform model is compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_sl_fifo_transmitter;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        SL0;
  logic        SL1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq [$];
  logic [1:0]  wave [$];
  int          rem;
  logic [5:0]  m_len;
  logic [2:0]  m_fm;
  logic        m_ovf;
  logic [1:0]  exp_sl;
  int          m_size;
  logic        m_flush, m_pop;
  logic [31:0] m_word;

  logic [1:0] samples [0:8999];

  int         a_off [15] = '{1, 2, 5, 6, 9, 10, 13, 14, 18, 66, 69, 70, 74, 81, 82};
  logic [1:0] a_exp [15] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11,
                             2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11};
  int         b_off [11] = '{1, 2, 129, 130, 258, 7938, 8194, 8449, 8450, 8705, 8706};
  logic [1:0] b_exp [11] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10,
                             2'b11, 2'b00, 2'b00, 2'b11};

  sl_fifo_transmitter #(
    .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .addr(addr),
    .d_in(d_in),
    .d_out(d_out),
    .SL0(SL0),
    .SL1(SL1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Appends the expected {SL0,SL1} sequence of one whole frame, starting the cycle after the pop.
  function automatic void push_level(input logic b, input int h);
    for (int i = 0; i < h; i++) wave.push_back({b, ~b});
    for (int i = 0; i < h; i++) wave.push_back(2'b11);
  endfunction

  function automatic void build_frame(input logic [31:0] w);
    int   len, h;
    logic par;
    len = (int'(m_len) / 2) * 2;
    if (len < 8) len = 8;
    if (len > DATA_W) len = DATA_W;
    h = 4 << ((m_fm > 3'd5) ? 5 : int'(m_fm));
    par = 1'b1;
    for (int i = 0; i < len; i++) begin
      push_level(w[i], h);
      par = par ^ w[i];
    end
    push_level(par, h);
    for (int i = 0; i < 2 * h; i++) wave.push_back(2'b00);
    for (int i = 0; i < 2 * h; i++) wave.push_back(2'b11);
    rem = 2 * h * (len + 3);
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[CNT_W-1:0] = CNT_W'(mq.size());
    s[16] = (rem != 0) || (mq.size() != 0);
    s[17] = (mq.size() == FIFO_DEPTH);
    s[18] = (mq.size() == 0);
    s[24] = m_ovf;
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      wave.delete();
      rem    = 0;
      m_len  = 6'd8;
      m_fm   = 3'd0;
      m_ovf  = 1'b0;
      exp_sl = 2'b11;
    end else begin
      m_size  = mq.size();
      m_flush = wr_en && (addr == 2'd1) && d_in[8];
      m_pop   = (rem == 0) && (m_size > 0) && !m_flush;
      if (rem > 0) rem--;
      if (wave.size() > 0) exp_sl = wave.pop_front();
      else exp_sl = 2'b11;
      if (m_flush) begin
        mq.delete();
        wave.delete();
        rem    = 0;
        exp_sl = 2'b11;
      end else begin
        if (m_pop) begin
          m_word = mq.pop_front();
          build_frame(m_word);
        end
        if (wr_en && (addr == 2'd0)) begin
          if (m_size < FIFO_DEPTH) mq.push_back(d_in);
          else m_ovf = 1'b1;
        end
      end
      if (wr_en && (addr == 2'd1)) begin
        m_len = d_in[5:0];
        m_fm  = {d_in[9], 1'b0, d_in[7]};
      end
      if (wr_en && (addr == 2'd2) && d_in[24]) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    check_output("sl_lines", {30'b0, SL0, SL1}, {30'b0, exp_sl});
    case (addr)
      2'd1:    check_output("config_read", d_out, {22'b0, m_fm, 1'b0, m_len});
      2'd2:    check_output("status_read", d_out, model_status());
      default: check_output("unused_read", d_out, 32'h0);
    endcase
  end

  // Called just after a rising edge; drives one cycle of inputs then returns to an idle STATUS read.
  task automatic apply_stimulus(input logic wr, input logic [1:0] a, input logic [31:0] d);
    wr_en = wr;
    addr  = a;
    d_in  = d;
    @(posedge clk);
    #2;
    wr_en = 1'b0;
    addr  = 2'd2;
    d_in  = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'd2, $urandom);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      samples[i] = {SL0, SL1};
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst   = 1'b0;
    wr_en = 1'b0;
    addr  = 2'd2;
    d_in  = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_output("reset_status", d_out, 32'h0004_0000);
    check_output("reset_lines", {30'b0, SL0, SL1}, 32'h3);
    @(posedge clk);
    #2 addr = 2'd1;
    @(negedge clk);
    check_output("reset_config", d_out, 32'h0000_0008);
    @(posedge clk);
    #2 addr = 2'd2;

    // 0xA5, length 8, mode 0: bit pulses of 4 cycles, parity 1, STOP 8 cycles
    apply_stimulus(1'b1, 2'd1, 32'h0000_0008);
    apply_stimulus(1'b1, 2'd0, 32'h0000_00A5);
    capture(95);
    for (int i = 0; i < 15; i++)
      check_output($sformatf("frame_a5_off%0d", a_off[i]), {30'b0, samples[a_off[i]]}, {30'b0, a_exp[i]});

    // all-ones word, length 32, mode 5 (H = 128)
    apply_stimulus(1'b1, 2'd1, 32'h0000_02A0);
    apply_stimulus(1'b1, 2'd0, 32'hFFFF_FFFF);
    capture(8970);
    for (int i = 0; i < 11; i++)
      check_output($sformatf("frame_long_off%0d", b_off[i]), {30'b0, samples[b_off[i]]}, {30'b0, b_exp[i]});

    // ten back-to-back words: one popped, eight stored, the tenth overflows
    apply_stimulus(1'b1, 2'd1, 32'h0000_0008);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 2'd0, $urandom);
    @(negedge clk);
    check_output("full_overflow_status", d_out, 32'h0103_0008);
    apply_stimulus(1'b1, 2'd2, 32'h0100_0000);
    @(negedge clk);
    check_output("overflow_cleared_status", d_out, 32'h0003_0008);
    idle_cycles(900);
    check_output("drained_status", d_out, 32'h0004_0000);

    // flush mid-bit with three words queued
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 2'd0, $urandom);
    idle_cycles(8);
    apply_stimulus(1'b1, 2'd1, 32'h0000_0108);
    @(negedge clk);
    check_output("flush_lines", {30'b0, SL0, SL1}, 32'h3);
    check_output("flush_status", d_out, 32'h0004_0000);
    idle_cycles(5);

    // reset pulse between edges in the middle of a frame
    apply_stimulus(1'b1, 2'd0, 32'h1234_5678);
    idle_cycles(20);
    rst = 1'b1;
    #1;
    check_output("async_reset_lines", {30'b0, SL0, SL1}, 32'h3);
    check_output("async_reset_status", d_out, 32'h0004_0000);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    apply_stimulus(1'b1, 2'd0, 32'h0000_003C);
    idle_cycles(100);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 12) begin
        apply_stimulus(1'b1, 2'd0, d);
      end else if (r < 15) begin
        d[5:0] = 6'($urandom_range(0, 40));
        d[9]   = 1'b0;
        d[8]   = ($urandom_range(0, 3) == 0);
        apply_stimulus(1'b1, 2'd1, d);
      end else if (r < 17) begin
        apply_stimulus(1'b1, 2'd2, d);
      end else if (r < 18) begin
        apply_stimulus(1'b1, 2'd3, d);
      end else begin
        apply_stimulus(1'b0, 2'($urandom_range(0, 3)), d);
      end
    end
    idle_cycles(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
